// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding NREQ requester lanes into one FIFO write port.
// A grant is issued only when the FIFO has room for a full burst, so a burst never overflows it.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int DEPTH     = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   input  logic [4:0]              fifo_cnt,
   output logic                    fifo_wr,
   output logic [WIDTH-1:0]        fifo_din,
   output logic [2:0]              grant_id,
   output logic                    busy
);

   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {ARB, BURST} state_t;

   state_t           state;
   logic [2:0]       owner;
   logic [2:0]       last_owner;
   logic [BW-1:0]    beat_cnt;
   logic [WIDTH-1:0] din_q;

   logic             own_valid;
   logic [WIDTH-1:0] own_data;
   logic             found;
   logic [2:0]       winner;
   logic             space_ok;
   logic             xfer;
   logic             last_beat;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == 3'(i)) begin
            own_valid = req_valid[i];
            own_data  = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Search starts just after the previous owner and wraps, giving round-robin fairness.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && req_valid[j] && j == (int'(last_owner) + k) % NREQ) begin
               found  = 1'b1;
               winner = 3'(j);
            end
         end
      end
   end

   assign space_ok  = {1'b0, fifo_cnt} <= 6'(DEPTH - MAX_BURST);
   assign xfer      = (state == BURST) && own_valid && !fifo_full;
   assign last_beat = beat_cnt == BW'(MAX_BURST - 1);

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++)
         req_ready[i] = (state == BURST) && (owner == 3'(i)) && !fifo_full;
   end

   // Write data passes straight through on a transfer and otherwise holds the last written word.
   assign fifo_wr  = xfer;
   assign fifo_din = xfer ? own_data : din_q;
   assign busy     = (state == BURST);
   assign grant_id = owner;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB;
         owner      <= '0;
         last_owner <= 3'(NREQ - 1);
         beat_cnt   <= '0;
         din_q      <= '0;
      end else begin
         case (state)
            ARB: begin
               if (found && space_ok) begin
                  owner    <= winner;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (!own_valid) begin
                  last_owner <= owner;
                  state      <= ARB;
               end else if (xfer) begin
                  din_q    <= own_data;
                  beat_cnt <= beat_cnt + BW'(1);
                  if (last_beat) begin
                     last_owner <= owner;
                     state      <= ARB;
                  end
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a rule-level model of grants, beats and lane words.
module tb_fifo_wr_arbiter;
   localparam int WIDTH     = 8;
   localparam int NREQ      = 4;
   localparam int DEPTH     = 16;
   localparam int MAX_BURST = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic [4:0]            fifo_cnt;
   logic                  fifo_wr;
   logic [WIDTH-1:0]      fifo_din;
   logic [2:0]            grant_id;
   logic                  busy;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Model: who holds the grant, how many beats it has moved, who was served last.
   bit               m_busy;
   int               m_owner, m_last, m_beats;
   logic [WIDTH-1:0] m_din;

   // Requesters: each lane presents lane_word until it is accepted, left words in total.
   logic [WIDTH-1:0] lane_word [NREQ];
   int               left [NREQ];
   int               seq [NREQ];
   bit [NREQ-1:0]    vmask;
   bit               rand_data;

   int               grants [$];
   bit               prev_busy;
   bit               wr_hist [$];
   logic [WIDTH-1:0] wr_data [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] next_word(int i);
      if (rand_data) return WIDTH'($urandom);
      return WIDTH'((i << 5) | (seq[i] & 31));
   endfunction

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                 = vmask[i] && (left[i] > 0);
         req_data[i*WIDTH +: WIDTH]   = lane_word[i];
      end
   endtask

   task automatic reset_checks();
      check("rst_busy",     32'(busy),      32'd0);
      check("rst_grant_id", 32'(grant_id),  32'd0);
      check("rst_req_ready",32'(req_ready), 32'd0);
      check("rst_fifo_wr",  32'(fifo_wr),   32'd0);
      check("rst_fifo_din", 32'(fifo_din),  32'd0);
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0; m_din = '0;
      prev_busy = 0;
      grants.delete(); wr_hist.delete(); wr_data.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b1; fifo_full = 1'b0; fifo_cnt = '0; vmask = '1;
      for (int i = 0; i < NREQ; i++) begin
         left[i] = 0; seq[i] = 0; lane_word[i] = next_word(i);
      end
      drive();
      #1 reset_checks();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One clock: compare outputs against the model, then advance model and requesters at the edge.
   task automatic step();
      logic             exp_wr;
      logic [NREQ-1:0]  exp_rdy;
      logic [WIDTH-1:0] exp_din;
      drive();
      #1;
      exp_rdy = (m_busy && !fifo_full) ? (NREQ'(1) << m_owner) : '0;
      exp_wr  = m_busy && req_valid[m_owner] && !fifo_full;
      exp_din = exp_wr ? lane_word[m_owner] : m_din;
      check("busy",      32'(busy),      32'(m_busy));
      if (m_busy) check("grant_id", 32'(grant_id), 32'(m_owner));
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("fifo_wr",   32'(fifo_wr),   32'(exp_wr));
      check("fifo_din",  32'(fifo_din),  32'(exp_din));
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
      wr_hist.push_back(fifo_wr);
      if (fifo_wr) wr_data.push_back(fifo_din);
      @(posedge clk);
      if (!m_busy) begin
         if (req_valid != '0 && DEPTH - int'(fifo_cnt) >= MAX_BURST) begin
            for (int k = NREQ; k >= 1; k--)
               if (req_valid[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
            m_busy  = 1;
            m_beats = 0;
         end
      end else if (!req_valid[m_owner]) begin
         m_last = m_owner;
         m_busy = 0;
      end else if (exp_wr) begin
         m_din = lane_word[m_owner];
         left[m_owner]--;
         seq[m_owner]++;
         lane_word[m_owner] = next_word(m_owner);
         m_beats++;
         if (m_beats == MAX_BURST) begin
            m_last = m_owner;
            m_busy = 0;
         end
      end
      @(negedge clk);
   endtask

   function automatic int wr_sum();
      int s = 0;
      foreach (wr_hist[i]) s += int'(wr_hist[i]);
      return s;
   endfunction

   initial begin
      int pattern;
      rand_data = 0;
      req_valid = '0; req_data = '0;

      // Single requester, 6 words: 4-beat burst, one ARB cycle, 2-beat burst.
      apply_reset();
      left[0] = 6;
      for (int c = 0; c < 10; c++) step();
      pattern = 0;
      foreach (wr_hist[i]) pattern = (pattern << 1) | int'(wr_hist[i]);
      check("single_wr_pattern", 32'(pattern), 32'b0111101100);
      check("single_wr_count",   32'(wr_data.size()), 32'd6);
      check("single_first_word", 32'(wr_data[0]), 32'h00);
      check("single_last_word",  32'(wr_data[5]), 32'h05);

      // All four requesting: grants rotate 0,1,2,3,0 with a single idle cycle between bursts.
      apply_reset();
      for (int i = 0; i < NREQ; i++) left[i] = 100;
      for (int c = 0; c < 25; c++) step();
      check("rr_wr_in_25", 32'(wr_sum()), 32'd20);
      check("rr_grant_cnt", 32'(grants.size()), 32'd5);
      check("rr_g0", 32'(grants[0]), 32'd0);
      check("rr_g1", 32'(grants[1]), 32'd1);
      check("rr_g2", 32'(grants[2]), 32'd2);
      check("rr_g3", 32'(grants[3]), 32'd3);
      check("rr_g4", 32'(grants[4]), 32'd0);

      // Space gating: 3 free words is not enough, 4 is.
      apply_reset();
      fifo_cnt = 5'd13; left[1] = 4;
      for (int c = 0; c < 3; c++) step();
      check("gate_no_grant", 32'(grants.size()), 32'd0);
      fifo_cnt = 5'd12;
      step(); step();
      check("gate_grant_cnt", 32'(grants.size()), 32'd1);
      check("gate_grant_id",  32'(grants[0]), 32'd1);

      // Full stall after 2 beats, then the remaining 2 beats complete.
      apply_reset();
      left[0] = 4;
      step(); step(); step();
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("stall_ready", 32'(req_ready), 32'd0);
         check("stall_wr",    32'(fifo_wr),   32'd0);
         check("stall_busy",  32'(busy),      32'd1);
      end
      fifo_full = 1'b0;
      step(); step(); step();
      check("stall_wr_total", 32'(wr_sum()), 32'd4);
      check("stall_last_word", 32'(wr_data[3]), 32'h03);
      check("stall_done_busy", 32'(busy), 32'd0);

      // Early end: owner 0 stops after one word, requester 2 wins next.
      apply_reset();
      left[0] = 1; left[2] = 4;
      for (int c = 0; c < 5; c++) step();
      check("early_grant_cnt", 32'(grants.size()), 32'd2);
      check("early_first",     32'(grants[0]), 32'd0);
      check("early_second",    32'(grants[1]), 32'd2);

      // Reset mid-burst kills the write at once; arbitration restarts from requester 0.
      apply_reset();
      left[0] = 10;
      step(); step(); step();
      rst = 1'b1;
      #1 reset_checks();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();
      vmask = 4'b1100; left[2] = 8; left[3] = 8;
      step(); step();
      check("rst_restart_cnt",   32'(grants.size()), 32'd1);
      check("rst_restart_grant", 32'(grants[0]), 32'd2);

      // Randomized traffic against the model.
      rand_data = 1;
      apply_reset();
      for (int i = 0; i < NREQ; i++) left[i] = 1000000;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 5) == 0) vmask[i] = ~vmask[i];
         fifo_full = ($urandom_range(0, 5) == 0);
         fifo_cnt  = 5'($urandom_range(0, DEPTH));
         step();
      end
      check("rand_activity", 32'(wr_data.size() > 300), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-003 SHALL have parameter DEPTH, default 16, meaning the capacity of the downstream FIFO in words.
REQ-004 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of words per grant (1..DEPTH).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, NREQ bits: requester i has a word on its lane.
REQ-008 SHALL have port req_data, input, NREQ*WIDTH bits: lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_ready, output, NREQ bits: word on lane i is accepted this cycle.
REQ-010 SHALL have port fifo_full, input, 1 bit: the FIFO full flag.
REQ-011 SHALL have port fifo_cnt, input, 5 bits: the FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port fifo_wr, output, 1 bit: the FIFO write strobe.
REQ-013 SHALL have port fifo_din, output, WIDTH bits: the FIFO write data.
REQ-014 SHALL have port grant_id, output, 3 bits: the index of the current owner; valid only while busy=1.
REQ-015 SHALL have port busy, output, 1 bit: a burst grant is active.

Function
REQ-016 SHALL implement two states, ARB and BURST, plus registers owner (3b), last_owner (3b) and beat_cnt (0..MAX_BURST).
REQ-017 In ARB, SHALL grant only when at least one req_valid is 1 and (DEPTH - fifo_cnt) >= MAX_BURST; otherwise it SHALL remain in ARB.
REQ-018 The winner SHALL be the first requester with req_valid=1, searching in order last_owner+1, last_owner+2, ... modulo NREQ (round-robin).
REQ-019 On a grant, SHALL load owner=winner, set beat_cnt=0 and enter BURST on the next edge; arbitration latency SHALL be 1 cycle and no transfer SHALL occur in the ARB cycle.
REQ-020 In BURST, req_ready[owner] SHALL equal !fifo_full combinationally; every other req_ready bit SHALL be 0.
REQ-021 A transfer is defined as BURST && req_valid[owner] && !fifo_full; in a transfer cycle fifo_wr SHALL be 1 and fifo_din SHALL equal the owner's lane in the same cycle (zero latency).
REQ-022 Outside a transfer, fifo_wr SHALL be 0 and fifo_din SHALL hold its last driven value.
REQ-023 Each transfer SHALL increment beat_cnt by 1.
REQ-024 BURST SHALL end at the edge where (a) the transfer brings beat_cnt to MAX_BURST, or (b) req_valid[owner]=0; at that edge the block SHALL set last_owner=owner and return to ARB.
REQ-025 If fifo_full=1 in BURST with req_valid[owner]=1, the block SHALL stall: no transfer, beat_cnt held, state held, no timeout.
REQ-026 Grants SHALL not be preempted; a higher-priority requester asserting mid-burst SHALL wait for the burst to end.
REQ-027 busy SHALL be 1 exactly while in BURST; grant_id SHALL equal owner.
REQ-028 A requester SHALL lose no word and receive no duplicate; every word accepted SHALL be written exactly once, in arrival order per lane.

Reset
REQ-029 While rst=1 (asynchronously): state=ARB, owner=0, last_owner=NREQ-1 (so requester 0 wins first), beat_cnt=0, fifo_wr=0, fifo_din=0, req_ready=0, busy=0, grant_id=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately with no further fifo_wr; after release, arbitration SHALL restart from requester 0.

Verification
REQ-031 Single requester: req_valid=0001, fifo_cnt=0, 6 words -> 1 ARB cycle, 4 consecutive fifo_wr, 1 ARB cycle, 2 fifo_wr, order preserved.
REQ-032 Round-robin: req_valid=1111 held -> grants 0,1,2,3,0 in order, 4 words each, busy low for 1 cycle between bursts.
REQ-033 Space gating: fifo_cnt=13, req_valid=0010 -> no grant (free=3 < 4); fifo_cnt drops to 12 -> grant_id=1 next cycle.
REQ-034 Full stall: in BURST after 2 beats, fifo_full=1 for 3 cycles -> fifo_wr=0, req_ready=0, beat_cnt=2 held; release -> remaining 2 beats complete.
REQ-035 Early end: owner drops req_valid after 1 beat -> return to ARB, last_owner=owner, next valid requester wins.
REQ-036 Mid-burst reset: rst=1 after beat 2 -> fifo_wr=0 same cycle, all outputs at reset values; after release with req_valid=1100 -> grant_id=2.
